// File: rtl/front_sprite_line_engine_pkg.sv
// Shared definitions for the front-layer scanline sprite engine:
// attribute field offsets, FSM states, transparent pen and hit test.
package front_spr_pkg;

   localparam int ATTR_X_LSB    = 0;
   localparam int ATTR_TILE_LSB = 8;
   localparam int ATTR_Y_LSB    = 16;
   localparam int ATTR_CTRL_LSB = 24;

   localparam int CTRL_COL_LSB  = 0;
   localparam int CTRL_XMSB_BIT = 4;
   localparam int CTRL_BANK_LSB = 5;
   localparam int CTRL_YMSB_BIT = 7;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_CHECK = 3'd2,
      ST_FETCH = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } spr_state_e;

   // Transparent pen is all ones in the low 'planes' bits.
   function automatic logic [7:0] TRANSP(input int planes);
      return 8'((1 << planes) - 1);
   endfunction

   function automatic logic spr_hit(input logic [8:0] v, input logic [8:0] y);
      logic [8:0] d;
      d = v - y;
      return (d < 9'd16);
   endfunction

   function automatic logic [3:0] spr_row(input logic [8:0] v, input logic [8:0] y);
      return 4'(v - y);
   endfunction

endpackage

// File: rtl/front_sprite_line_engine_buffer.sv
// Double-banked 512-entry line buffer: one bank is composed while the
// other is displayed and cleared behind the read.
module front_line_buffer #(
   parameter int W     = 7,
   parameter int PEN_W = 3
) (
   input  logic         clk,
   input  logic         VIDEO_RST,
   input  logic         swap,
   input  logic         wr_en,
   input  logic [8:0]   wr_addr,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   input  logic [8:0]   rd_addr,
   output logic [W-1:0] rd_data
);

   localparam logic [W-1:0]     CLR      = W'((1 << PEN_W) - 1);
   localparam logic [PEN_W-1:0] PEN_ONES = {PEN_W{1'b1}};

   logic [W-1:0] mem_r [0:1023];
   logic         sel_r;
   logic         wr_ok_s;

   // A compose write only lands on a location that is still transparent
   always_comb begin
      wr_ok_s = 1'b0;
      if (wr_en) begin
         wr_ok_s = (mem_r[{sel_r, wr_addr}][PEN_W-1:0] == PEN_ONES);
      end else begin
         wr_ok_s = 1'b0;
      end
   end

   // Storage: compose port hits bank sel_r, display port clears the other bank
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_r[{sel_r, wr_addr}] <= wr_data;
      end
      if (rd_en) begin
         mem_r[{~sel_r, rd_addr}] <= CLR;
      end
   end

   // Bank select and registered display read
   always_ff @(posedge clk) begin
      if (VIDEO_RST) begin
         sel_r   <= 1'b0;
         rd_data <= CLR;
      end else begin
         if (swap) begin
            sel_r <= ~sel_r;
         end
         if (rd_en) begin
            rd_data <= mem_r[{~sel_r, rd_addr}];
         end
      end
   end

endmodule

// File: rtl/front_sprite_line_engine.sv
// Scanline front-sprite renderer: scans attribute RAM, fetches pattern rows
// over req/ack and composes them into a line buffer shown on the next line.
module front_sprite_line_engine
   import front_spr_pkg::*;
#(
   parameter int NUM_SPR      = 64,
   parameter int MAX_PER_LINE = 16,
   parameter int PLANES       = 3,
   parameter int COLW         = 4,
   parameter int ROM_AW       = 15
) (
   input  logic                       clk,
   input  logic                       VIDEO_RST,
   input  logic                       line_start,
   input  logic [8:0]                 next_v,
   output logic [$clog2(NUM_SPR)-1:0] attr_addr,
   output logic                       attr_rd,
   input  logic [31:0]                attr_q,
   output logic [ROM_AW-1:0]          rom_addr,
   output logic                       rom_req,
   input  logic                       rom_ack,
   input  logic [PLANES*8-1:0]        rom_data,
   input  logic                       pix_cen,
   input  logic [8:0]                 pix_x,
   output logic [COLW+PLANES-1:0]     pix_out,
   output logic                       busy,
   output logic                       overflow
);

   localparam int               IW       = $clog2(NUM_SPR);
   localparam int               HW       = $clog2(MAX_PER_LINE + 1);
   localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_SPR - 1);
   localparam logic [HW-1:0]    MAX_HITS = HW'(MAX_PER_LINE);
   localparam logic [PLANES-1:0] PEN_T   = PLANES'(TRANSP(PLANES));

   spr_state_e            state_r, state_s;
   logic [IW-1:0]         idx_r;
   logic [HW-1:0]         hits_r;
   logic [8:0]            line_v_r;
   logic [8:0]            spr_x_r;
   logic [COLW-1:0]       colour_r;
   logic [1:0]            bank_r;
   logic [7:0]            tile_r;
   logic [3:0]            row_r;
   logic                  half_r;
   logic [2:0]            k_r;
   logic [PLANES*8-1:0]   pat_r;
   logic                  attr_rd_r, rom_req_r, busy_r, overflow_r;
   logic [ROM_AW-1:0]     rom_addr_r;

   logic [8:0]            y_s, x_s;
   logic                  hit_s, last_s, full_s, scanning_s;
   logic [PLANES-1:0]     pen_s;
   logic [8:0]            wr_addr_s;
   logic                  wr_en_s;

   function automatic logic [ROM_AW-1:0] mk_rom_addr(input logic [1:0] b, input logic [7:0] t,
                                                      input logic [3:0] r, input logic h);
      return ROM_AW'({b, t, r, h});
   endfunction

   // Next-state logic; line_start always restarts the scan from entry 0
   always_comb begin
      state_s    = state_r;
      y_s        = {attr_q[ATTR_CTRL_LSB + CTRL_YMSB_BIT], attr_q[ATTR_Y_LSB +: 8]};
      x_s        = {attr_q[ATTR_CTRL_LSB + CTRL_XMSB_BIT], attr_q[ATTR_X_LSB +: 8]};
      hit_s      = spr_hit(line_v_r, y_s);
      last_s     = (idx_r == LAST_IDX);
      full_s     = (hits_r == MAX_HITS);
      scanning_s = (state_r == ST_READ) || (state_r == ST_CHECK) ||
                   (state_r == ST_FETCH) || (state_r == ST_WRITE);
      if (line_start) begin
         state_s = ST_READ;
      end else begin
         case (state_r)
            ST_IDLE:  state_s = ST_IDLE;
            ST_READ:  state_s = ST_CHECK;
            ST_CHECK: begin
               if (hit_s) begin
                  state_s = full_s ? ST_DONE : ST_FETCH;
               end else begin
                  state_s = last_s ? ST_DONE : ST_READ;
               end
            end
            ST_FETCH: state_s = rom_ack ? ST_WRITE : ST_FETCH;
            ST_WRITE: begin
               if (k_r == 3'd7) begin
                  if (!half_r) begin
                     state_s = ST_FETCH;
                  end else begin
                     state_s = last_s ? ST_DONE : ST_READ;
                  end
               end else begin
                  state_s = ST_WRITE;
               end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
         endcase
      end
   end

   // Pixel k of the latched pattern row; ROM bits are stored inverted
   always_comb begin
      pen_s = {PLANES{1'b0}};
      for (int p = 0; p < PLANES; p++) begin
         pen_s[p] = ~pat_r[p*8 + 7 - int'(k_r)];
      end
      wr_addr_s = spr_x_r + {5'd0, half_r, k_r};
      wr_en_s   = (state_r == ST_WRITE) && (pen_s != PEN_T);
   end

   // State, strobes and sprite datapath registers
   always_ff @(posedge clk) begin
      if (VIDEO_RST) begin
         state_r    <= ST_IDLE;
         idx_r      <= {IW{1'b0}};
         hits_r     <= {HW{1'b0}};
         line_v_r   <= 9'd0;
         spr_x_r    <= 9'd0;
         colour_r   <= {COLW{1'b0}};
         bank_r     <= 2'd0;
         tile_r     <= 8'd0;
         row_r      <= 4'd0;
         half_r     <= 1'b0;
         k_r        <= 3'd0;
         pat_r      <= {(PLANES*8){1'b0}};
         attr_rd_r  <= 1'b0;
         rom_req_r  <= 1'b0;
         busy_r     <= 1'b0;
         overflow_r <= 1'b0;
         rom_addr_r <= {ROM_AW{1'b0}};
      end else begin
         state_r   <= state_s;
         attr_rd_r <= (state_s == ST_READ);
         rom_req_r <= (state_s == ST_FETCH);
         busy_r    <= (state_s != ST_IDLE);
         if (line_start) begin
            line_v_r   <= next_v;
            idx_r      <= {IW{1'b0}};
            hits_r     <= {HW{1'b0}};
            overflow_r <= scanning_s;
         end else begin
            case (state_r)
               ST_CHECK: begin
                  if (hit_s) begin
                     if (full_s) begin
                        overflow_r <= 1'b1;
                     end else begin
                        hits_r     <= hits_r + HW'(1);
                        spr_x_r    <= x_s;
                        colour_r   <= COLW'(attr_q[ATTR_CTRL_LSB + CTRL_COL_LSB +: 4]);
                        bank_r     <= attr_q[ATTR_CTRL_LSB + CTRL_BANK_LSB +: 2];
                        tile_r     <= attr_q[ATTR_TILE_LSB +: 8];
                        row_r      <= spr_row(line_v_r, y_s);
                        half_r     <= 1'b0;
                        rom_addr_r <= mk_rom_addr(attr_q[ATTR_CTRL_LSB + CTRL_BANK_LSB +: 2],
                                                  attr_q[ATTR_TILE_LSB +: 8],
                                                  spr_row(line_v_r, y_s), 1'b0);
                     end
                  end else if (!last_s) begin
                     idx_r <= idx_r + IW'(1);
                  end
               end
               ST_FETCH: begin
                  if (rom_ack) begin
                     pat_r <= rom_data;
                     k_r   <= 3'd0;
                  end
               end
               ST_WRITE: begin
                  k_r <= k_r + 3'd1;
                  if (k_r == 3'd7) begin
                     if (!half_r) begin
                        half_r     <= 1'b1;
                        rom_addr_r <= mk_rom_addr(bank_r, tile_r, row_r, 1'b1);
                     end else if (!last_s) begin
                        idx_r <= idx_r + IW'(1);
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign attr_addr = idx_r;
   assign attr_rd   = attr_rd_r;
   assign rom_addr  = rom_addr_r;
   assign rom_req   = rom_req_r;
   assign busy      = busy_r;
   assign overflow  = overflow_r;

   front_line_buffer #(
      .W     (COLW + PLANES),
      .PEN_W (PLANES)
   ) u_buf (
      .clk       (clk),
      .VIDEO_RST (VIDEO_RST),
      .swap      (line_start),
      .wr_en     (wr_en_s),
      .wr_addr   (wr_addr_s),
      .wr_data   ({colour_r, pen_s}),
      .rd_en     (pix_cen),
      .rd_addr   (pix_x),
      .rd_data   (pix_out)
   );

endmodule

// File: tb/tb_front_sprite_line_engine.sv
// Directed bench for front_sprite_line_engine with attribute RAM and
// pattern ROM models; expected pixels are hand-computed constants.
module tb_front_sprite_line_engine;

   logic        clk = 1'b0;
   logic        VIDEO_RST;
   logic        line_start;
   logic [8:0]  next_v;
   logic [5:0]  attr_addr;
   logic        attr_rd;
   logic [31:0] attr_q = 32'd0;
   logic [14:0] rom_addr;
   logic        rom_req;
   logic        rom_ack = 1'b0;
   logic [23:0] rom_data = 24'd0;
   logic        pix_cen;
   logic [8:0]  pix_x;
   logic [6:0]  pix_out;
   logic        busy;
   logic        overflow;

   localparam int ROM_LAT = 2;

   logic [31:0] attr_mem [0:63];
   logic [23:0] rom_mem  [0:32767];
   logic [14:0] rom_log  [0:63];
   int          rom_n = 0;
   int          rom_cnt = 0;
   logic        rom_stall;
   logic [6:0]  line_px  [0:511];
   int          checks = 0;
   int          errors = 0;
   int          base;

   front_sprite_line_engine dut (
      .clk        (clk),
      .VIDEO_RST  (VIDEO_RST),
      .line_start (line_start),
      .next_v     (next_v),
      .attr_addr  (attr_addr),
      .attr_rd    (attr_rd),
      .attr_q     (attr_q),
      .rom_addr   (rom_addr),
      .rom_req    (rom_req),
      .rom_ack    (rom_ack),
      .rom_data   (rom_data),
      .pix_cen    (pix_cen),
      .pix_x      (pix_x),
      .pix_out    (pix_out),
      .busy       (busy),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (attr_rd) attr_q <= attr_mem[attr_addr];
   end

   always @(posedge clk) begin
      if (rom_ack) begin
         rom_ack <= 1'b0;
         rom_cnt <= 0;
      end else if (rom_req && !rom_stall) begin
         if (rom_cnt == ROM_LAT) begin
            rom_ack  <= 1'b1;
            rom_data <= rom_mem[rom_addr];
            if (rom_n < 64) rom_log[rom_n] <= rom_addr;
            rom_n <= rom_n + 1;
         end else begin
            rom_cnt <= rom_cnt + 1;
         end
      end else begin
         rom_cnt <= 0;
      end
   end

   function automatic logic [31:0] ent(input logic [3:0] col, input logic [1:0] bank,
                                       input logic [8:0] x, input logic [8:0] y, input logic [7:0] tile);
      return {y[8], bank, x[8], col, y[7:0], tile, x[7:0]};
   endfunction

   function automatic int count_opaque();
      int n = 0;
      for (int i = 0; i < 512; i++) if (line_px[i] !== 7'h07) n++;
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_line(input logic [8:0] v);
      line_start = 1'b1;
      next_v     = v;
      @(negedge clk);
      line_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!rom_req && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(rom_req), 32'd1);
   endtask

   task automatic show_line();
      pix_cen = 1'b1;
      for (int x = 0; x < 512; x++) begin
         pix_x = 9'(x);
         @(negedge clk);
         line_px[x] = pix_out;
      end
      pix_cen = 1'b0;
   endtask

   initial begin
      VIDEO_RST = 1'b1;
      line_start = 1'b0;
      next_v = 9'd0;
      pix_cen = 1'b0;
      pix_x = 9'd0;
      rom_stall = 1'b0;
      for (int i = 0; i < 32768; i++) rom_mem[i] = 24'd0;
      for (int i = 0; i < 64; i++) attr_mem[i] = ent(4'd0, 2'd0, 9'd0, 9'h100, 8'd0);
      repeat (3) @(negedge clk);

      check("rst attr_rd", 32'(attr_rd), 32'd0);
      check("rst rom_req", 32'(rom_req), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst overflow", 32'(overflow), 32'd0);
      check("rst rom_addr", 32'(rom_addr), 32'd0);
      check("rst attr_addr", 32'(attr_addr), 32'd0);
      check("rst pix_out", 32'(pix_out), 32'h07);
      VIDEO_RST = 1'b0;
      @(negedge clk);

      // Flush both banks once so every location starts transparent
      repeat (2) begin
         start_line(9'h0F0);
         wait_idle("prep idle");
         show_line();
      end

      // Sprite 0 single hit
      attr_mem[0] = ent(4'd3, 2'd2, 9'h010, 9'h020, 8'h05);
      rom_mem[15'h40AA] = 24'h000080;
      base = rom_n;
      start_line(9'h025);
      wait_idle("t1 idle");
      check("t1 fetches", 32'(rom_n - base), 32'd2);
      check("t1 addr h0", 32'(rom_log[base]), 32'h40AA);
      check("t1 addr h1", 32'(rom_log[base + 1]), 32'h40AB);
      check("t1 overflow", 32'(overflow), 32'd0);
      start_line(9'h0F0);
      show_line();
      wait_idle("t1 flush idle");
      check("t1 px010", 32'(line_px[16]), 32'h1E);
      check("t1 opaque cnt", 32'(count_opaque()), 32'd1);

      // Y wrap (row 11) with horizontal wrap past 511
      attr_mem[0] = ent(4'd5, 2'd0, 9'h1FC, 9'h1F8, 8'h11);
      rom_mem[15'h236] = 24'hFFFFFF;
      base = rom_n;
      start_line(9'h003);
      wait_idle("t2 idle");
      check("t2 fetches", 32'(rom_n - base), 32'd2);
      check("t2 addr h0", 32'(rom_log[base]), 32'h236);
      start_line(9'h0F0);
      show_line();
      wait_idle("t2 flush idle");
      check("t2 px1FC", 32'(line_px[9'h1FC]), 32'h28);
      check("t2 px003", 32'(line_px[3]), 32'h28);
      check("t2 px004", 32'(line_px[4]), 32'h07);
      check("t2 px1FB", 32'(line_px[9'h1FB]), 32'h07);
      check("t2 opaque cnt", 32'(count_opaque()), 32'd8);

      // Priority: sprite 0 covers 0x40-0x43, sprite 1 shows through elsewhere
      attr_mem[0] = ent(4'd1, 2'd0, 9'h040, 9'h050, 8'h01);
      attr_mem[1] = ent(4'd2, 2'd0, 9'h040, 9'h050, 8'h02);
      rom_mem[15'h020] = 24'hF0F000;
      rom_mem[15'h040] = 24'hFF00FF;
      start_line(9'h050);
      wait_idle("t3 idle");
      start_line(9'h0F0);
      show_line();
      wait_idle("t3 flush idle");
      check("t3 px040", 32'(line_px[9'h040]), 32'h09);
      check("t3 px043", 32'(line_px[9'h043]), 32'h09);
      check("t3 px044", 32'(line_px[9'h044]), 32'h12);
      check("t3 px047", 32'(line_px[9'h047]), 32'h12);
      check("t3 px048", 32'(line_px[9'h048]), 32'h07);
      check("t3 opaque cnt", 32'(count_opaque()), 32'd8);

      // Overflow: 20 hitting sprites, only 16 drawn
      for (int i = 0; i < 20; i++) attr_mem[i] = ent(4'd7, 2'd0, 9'(i * 16), 9'h060, 8'h03);
      rom_mem[15'h060] = 24'hFFFFFF;
      rom_mem[15'h061] = 24'hFFFFFF;
      base = rom_n;
      start_line(9'h060);
      wait_idle("t4 idle");
      check("t4 overflow", 32'(overflow), 32'd1);
      check("t4 fetches", 32'(rom_n - base), 32'd32);
      start_line(9'h0F0);
      check("t4 overflow clr", 32'(overflow), 32'd0);
      show_line();
      wait_idle("t4 flush idle");
      check("t4 opaque cnt", 32'(count_opaque()), 32'd256);
      check("t4 px0FF", 32'(line_px[255]), 32'h38);
      check("t4 px100", 32'(line_px[256]), 32'h07);

      // Clear-after-read: the bank just displayed must come back empty
      for (int i = 0; i < 64; i++) attr_mem[i] = ent(4'd0, 2'd0, 9'd0, 9'h100, 8'd0);
      start_line(9'h070);
      wait_idle("t5 idle");
      start_line(9'h0F0);
      show_line();
      wait_idle("t5 flush idle");
      check("t5 opaque cnt", 32'(count_opaque()), 32'd0);

      // ROM stall then abort by line_start
      attr_mem[0] = ent(4'd0, 2'd0, 9'h020, 9'h080, 8'h04);
      rom_stall = 1'b1;
      base = rom_n;
      start_line(9'h080);
      wait_req("t6 req seen");
      repeat (5) @(negedge clk);
      check("t6 req held", 32'(rom_req), 32'd1);
      check("t6 addr stable", 32'(rom_addr), 32'h080);
      start_line(9'h0F0);
      check("t6 req drop", 32'(rom_req), 32'd0);
      check("t6 abort ovf", 32'(overflow), 32'd1);
      check("t6 restart rd", 32'(attr_rd), 32'd1);
      check("t6 restart idx", 32'(attr_addr), 32'd0);
      rom_stall = 1'b0;
      wait_idle("t6 idle");
      check("t6 ovf kept", 32'(overflow), 32'd1);
      check("t6 no fetch", 32'(rom_n - base), 32'd0);

      // Reset during a stalled fetch
      rom_stall = 1'b1;
      start_line(9'h080);
      wait_req("t7 req seen");
      VIDEO_RST = 1'b1;
      @(negedge clk);
      check("t7 req rst", 32'(rom_req), 32'd0);
      check("t7 busy rst", 32'(busy), 32'd0);
      check("t7 ovf rst", 32'(overflow), 32'd0);
      VIDEO_RST = 1'b0;
      rom_stall = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
